// File: rtl/sram_bus_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-bus arbiter with in-order response tags; ARB_CANCEL_EN enables flush discard.
// Latency: zero-cycle request and response paths; tag FIFO, count, lock and resp_err update on the next clk edge.
// Backpressure: m_req is withheld while MAX_OUTSTANDING requests are unanswered; a stalled grant stays locked to its port.
module sram_bus_arbiter #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int ADDR_W          = 32
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [3:0]        inst_wstrb,
   input  logic [31:0]       inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [31:0]       inst_rdata,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [3:0]        data_wstrb,
   input  logic [31:0]       data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [31:0]       data_rdata,

   output logic              m_req,
   output logic              m_wr,
   output logic [1:0]        m_size,
   output logic [ADDR_W-1:0] m_addr,
   output logic [3:0]        m_wstrb,
   output logic [31:0]       m_wdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   input  logic [31:0]       m_rdata,

   input  logic              flush,
   output logic              busy,
   output logic              resp_err
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             lock;
   logic             locked_src;
   logic             tag_src [MAX_OUTSTANDING];

   logic             full;
   logic             win_src;
   logic             push;
   logic             pop;
   logic             head_src;
   logic             head_discard;

   assign full    = (count == FULL_CNT);
   assign win_src = lock ? locked_src : data_req;

   assign m_req   = (inst_req | data_req) & ~full;
   assign m_wr    = win_src ? data_wr    : inst_wr;
   assign m_size  = win_src ? data_size  : inst_size;
   assign m_addr  = win_src ? data_addr  : inst_addr;
   assign m_wstrb = win_src ? data_wstrb : inst_wstrb;
   assign m_wdata = win_src ? data_wdata : inst_wdata;

   assign push         = m_req & m_addr_ok;
   assign inst_addr_ok = push & ~win_src;
   assign data_addr_ok = push &  win_src;

   assign pop      = m_data_ok & (count != '0);
   assign head_src = tag_src[rd_ptr];

`ifdef ARB_CANCEL_EN
   logic tag_discard [MAX_OUTSTANDING];

   // A response popped during the flush cycle belongs to squashed work too.
   assign head_discard = tag_discard[rd_ptr] | flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) tag_discard[i] <= 1'b0;
      end else begin
         // Marking free slots as well is harmless: a push overwrites them.
         if (flush) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_discard[i] <= 1'b1;
         end
         if (push) tag_discard[wr_ptr] <= flush;
      end
   end
`else
   logic unused_flush;

   assign unused_flush = flush;
   assign head_discard = 1'b0;
`endif

   assign inst_data_ok = pop & ~head_discard & ~head_src;
   assign data_data_ok = pop & ~head_discard &  head_src;
   assign inst_rdata   = m_rdata;
   assign data_rdata   = m_rdata;
   assign busy         = (count != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         lock       <= 1'b0;
         locked_src <= 1'b0;
         resp_err   <= 1'b0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) tag_src[i] <= 1'b0;
      end else begin
         // Hold the grant on a stalled handshake so fields stay stable downstream.
         if (m_req && !m_addr_ok) begin
            lock       <= 1'b1;
            locked_src <= win_src;
         end else if (m_req && m_addr_ok) begin
            lock <= 1'b0;
         end

         if (push) begin
            tag_src[wr_ptr] <= win_src;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         if (m_data_ok && count == '0) resp_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter.
module tb_sram_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, data_addr;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic [31:0] inst_wdata, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        m_req, m_wr;
   logic [1:0]  m_size;
   logic [31:0] m_addr;
   logic [3:0]  m_wstrb;
   logic [31:0] m_wdata;
   logic        m_addr_ok, m_data_ok;
   logic [31:0] m_rdata;
   logic        flush, busy, resp_err;

   int n_checks = 0;
   int n_fail   = 0;

   sram_bus_arbiter #(.MAX_OUTSTANDING(4), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb),
      .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .flush(flush), .busy(busy), .resp_err(resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
      m_addr_ok = 0; m_data_ok = 0; m_rdata = 0; flush = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      set_idle();
      reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
      #1;
      n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req got=%0b want=0", m_req); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", busy); end
      n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got=%0b want=0", resp_err); end
      n_checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_handshakes got=%b want=0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
      end
   endtask

   task automatic test_priority();
      inst_req = 1; inst_addr = 32'h100; inst_wr = 0;
      data_req = 1; data_addr = 32'h200; data_wr = 1; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF;
      m_addr_ok = 1;
      #1;
      n_checks++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL prio_data_addr_ok got=%0b want=1", data_addr_ok); end
      n_checks++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL prio_inst_addr_ok got=%0b want=0", inst_addr_ok); end
      n_checks++; if (m_addr !== 32'h200) begin n_fail++; $display("FAIL prio_m_addr got=%h want=200", m_addr); end
      n_checks++; if ({m_wr, m_wstrb, m_wdata} !== {1'b1, 4'hF, 32'hDEAD_BEEF}) begin
         n_fail++; $display("FAIL prio_fields got=%0b/%h/%h want=1/f/deadbeef", m_wr, m_wstrb, m_wdata);
      end
      tick();
      data_req = 0;
      #1;
      n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL prio_inst_next got=%0b want=1", inst_addr_ok); end
      n_checks++; if ({m_addr, m_wr} !== {32'h100, 1'b0}) begin n_fail++; $display("FAIL prio_inst_fields got=%h/%0b want=100/0", m_addr, m_wr); end
      tick();
      set_idle();
      m_data_ok = 1; m_rdata = 32'h11;
      #1;
      n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL prio_resp0 got=%b want=01", {inst_data_ok, data_data_ok}); end
      n_checks++; if (data_rdata !== 32'h11) begin n_fail++; $display("FAIL prio_rdata got=%h want=11", data_rdata); end
      tick();
      m_rdata = 32'h22;
      #1;
      n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL prio_resp1 got=%b want=10", {inst_data_ok, data_data_ok}); end
      tick();
      set_idle();
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_busy_end got=%0b want=0", busy); end
   endtask

   task automatic test_lock();
      inst_req = 1; inst_addr = 32'h300; m_addr_ok = 0;
      #1;
      n_checks++; if ({m_req, inst_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_c1 got=%b want=10", {m_req, inst_addr_ok}); end
      tick();
      data_req = 1; data_addr = 32'h400;
      #1;
      n_checks++; if (m_addr !== 32'h300) begin n_fail++; $display("FAIL lock_c2_addr got=%h want=300", m_addr); end
      n_checks++; if (data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL lock_c2_data_ok got=%0b want=0", data_addr_ok); end
      tick();
      #1;
      n_checks++; if (m_addr !== 32'h300) begin n_fail++; $display("FAIL lock_c3_addr got=%h want=300", m_addr); end
      tick();
      m_addr_ok = 1;
      #1;
      n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_c4_accept got=%b want=10", {inst_addr_ok, data_addr_ok}); end
      tick();
      inst_req = 0;
      #1;
      n_checks++; if ({data_addr_ok, m_addr} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL lock_c5_data got=%0b/%h want=1/400", data_addr_ok, m_addr); end
      tick();
      set_idle();
      m_data_ok = 1;
      #1;
      n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_resp0 got=%b want=10", {inst_data_ok, data_data_ok}); end
      tick();
      #1;
      n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL lock_resp1 got=%b want=01", {inst_data_ok, data_data_ok}); end
      tick();
      set_idle();
   endtask

   task automatic test_ordering();
      logic [31:0] rd [3];
      logic [1:0]  want [3];
      rd[0] = 32'hA; rd[1] = 32'hB; rd[2] = 32'hC;
      want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b10;
      m_addr_ok = 1;
      inst_req = 1; inst_addr = 32'h100; tick();
      inst_req = 0; data_req = 1; data_addr = 32'h200; tick();
      data_req = 0; inst_req = 1; inst_addr = 32'h104; tick();
      set_idle();
      for (int i = 0; i < 3; i++) begin
         m_data_ok = 1; m_rdata = rd[i];
         #1;
         n_checks++; if ({inst_data_ok, data_data_ok} !== want[i]) begin
            n_fail++; $display("FAIL order_resp%0d got=%b want=%b", i, {inst_data_ok, data_data_ok}, want[i]);
         end
         n_checks++; if ((want[i][1] ? inst_rdata : data_rdata) !== rd[i]) begin
            n_fail++; $display("FAIL order_rdata%0d got=%h want=%h", i, want[i][1] ? inst_rdata : data_rdata, rd[i]);
         end
         tick();
      end
      set_idle();
   endtask

   task automatic test_full();
      m_addr_ok = 1; inst_req = 1;
      for (int i = 0; i < 4; i++) begin
         inst_addr = 32'h1000 + 32'(4 * i);
         tick();
      end
      m_data_ok = 1;
      #1;
      n_checks++; if ({m_req, inst_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL full_block got=%b want=00", {m_req, inst_addr_ok}); end
      n_checks++; if ({inst_data_ok, busy} !== 2'b11) begin n_fail++; $display("FAIL full_pop got=%b want=11", {inst_data_ok, busy}); end
      tick();
      m_data_ok = 0; m_addr_ok = 0;
      #1;
      n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL full_reopen got=%0b want=1", m_req); end
      #1;
      set_idle();
      for (int i = 0; i < 3; i++) begin
         m_data_ok = 1;
         #1;
         n_checks++; if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL full_drain%0d got=%0b want=1", i, inst_data_ok); end
         tick();
      end
      set_idle();
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end got=%0b want=0", busy); end
   endtask

   task automatic test_flush();
      logic [3:0] exp_i;
      logic [3:0] exp_d;
`ifdef ARB_CANCEL_EN
      exp_i = 4'b0000; exp_d = 4'b1000;
`else
      exp_i = 4'b0101; exp_d = 4'b1010;
`endif
      m_addr_ok = 1;
      inst_req = 1; inst_addr = 32'h10; tick();
      inst_req = 0; data_req = 1; data_addr = 32'h20; tick();
      data_req = 0; inst_req = 1; inst_addr = 32'h30; flush = 1;
      #1;
      n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL flush_accept got=%0b want=1", inst_addr_ok); end
      tick();
      flush = 0; inst_req = 0; data_req = 1; data_addr = 32'h40; tick();
      set_idle();
      for (int i = 0; i < 4; i++) begin
         m_data_ok = 1;
         #1;
         n_checks++; if ({inst_data_ok, data_data_ok} !== {exp_i[i], exp_d[i]}) begin
            n_fail++; $display("FAIL flush_resp%0d got=%b want=%b", i, {inst_data_ok, data_data_ok}, {exp_i[i], exp_d[i]});
         end
         tick();
      end
      set_idle();
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_end got=%0b want=0", busy); end
   endtask

   task automatic test_back_to_back();
      m_addr_ok = 1; inst_req = 1; inst_addr = 32'h50; tick();
      inst_req = 0; data_req = 1; data_addr = 32'h60; m_data_ok = 1;
      #1;
      n_checks++; if ({data_addr_ok, inst_data_ok} !== 2'b11) begin n_fail++; $display("FAIL b2b_concurrent got=%b want=11", {data_addr_ok, inst_data_ok}); end
      tick();
      set_idle();
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%0b want=1", busy); end
      m_data_ok = 1;
      #1;
      n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL b2b_resp got=%b want=01", {inst_data_ok, data_data_ok}); end
      tick();
      set_idle();
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got=%0b want=0", busy); end
   endtask

   task automatic test_error();
      set_idle();
      m_data_ok = 1;
      #1;
      n_checks++; if ({inst_data_ok, data_data_ok, resp_err} !== 3'b000) begin
         n_fail++; $display("FAIL err_drop got=%b want=000", {inst_data_ok, data_data_ok, resp_err});
      end
      tick();
      m_data_ok = 0;
      #1;
      n_checks++; if ({resp_err, busy} !== 2'b10) begin n_fail++; $display("FAIL err_set got=%b want=10", {resp_err, busy}); end
      m_addr_ok = 1; inst_req = 1; inst_addr = 32'h70; tick();
      set_idle();
      m_data_ok = 1;
      #1;
      n_checks++; if (inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL err_normal_resp got=%0b want=1", inst_data_ok); end
      tick();
      set_idle();
      #1;
      n_checks++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%0b want=1", resp_err); end
      reset = 1;
      tick();
      reset = 0;
      #1;
      n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL err_reset_clear got=%0b want=0", resp_err); end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_lock();
      test_ordering();
      test_full();
      test_flush();
      test_back_to_back();
      test_error();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-master to one-slave arbiter for the SRAM-like (req / addr_ok / data_ok) bus that sits between the core and the AXI bridge. The instruction-fetch port and the data port, which the MEM stages drive, share one downstream bus. The block grants requests with data priority and a locked handshake. It tracks up to MAX_OUTSTANDING accepted requests in an in-order tag FIFO and routes each data_ok back to its originating port. On a pipeline flush it discards responses for requests already in flight.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered requests. Must be a power of 2, ≥2.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- inst_req / data_req  in  1  request from the instruction / data master
- inst_wr / data_wr  in  1  write (1) or read (0)
- inst_size / data_size  in  2  access size: 0 = byte, 1 = half, 2 = word
- inst_addr / data_addr  in  ADDR_W  request address
- inst_wstrb / data_wstrb  in  4  byte enables
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  response for this port this cycle
- inst_rdata / data_rdata  out  32  equal to m_rdata, unregistered
- m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata  out  —  downstream request, fields muxed from the granted port
- m_addr_ok  in  1  downstream accepted the request
- m_data_ok  in  1  downstream response
- m_rdata  in  32  downstream read data
- flush  in  1  pipeline flush (pipeline_flush.flush)
- busy  out  1  outstanding count ≠ 0
- resp_err  out  1  sticky; set when m_data_ok arrives with the FIFO empty

## Operation
- **Occupancy:** count holds 0..MAX_OUTSTANDING, width $clog2(MAX_OUTSTANDING)+1. full = (count == MAX_OUTSTANDING).
- **Grant:**
  - lock = 0: winner = data if data_req, else inst.
  - lock = 1: winner = locked_src.
- **Request output:** m_req = (inst_req | data_req) & !full. Downstream fields come from the winner.
- **Lock rule:**
  - When m_req=1 and m_addr_ok=0, set lock=1 and locked_src=winner.
  - Clear lock on the cycle m_addr_ok=1.
  - A granted port never loses the bus mid-handshake, even if the other port raises req.
- **Accept:** winner's addr_ok = m_req & m_addr_ok. The loser's addr_ok is 0.
- **Push:** on accept, push tag {src, discard}. src = 0 for inst, 1 for data.
- **Pop:** on m_data_ok with count>0, pop the head tag.
  - If discard=0, pulse data_ok on port src.
  - If discard=1, no data_ok on either port.
- **Counter update:** simultaneous push and pop leaves count unchanged. Push is blocked when full, even if a pop occurs the same cycle; there is no bypass.
- **Empty FIFO:** m_data_ok with count=0 is dropped and sets resp_err. Only reset clears resp_err.
- **Flush:** sets discard on every valid entry, plus the entry pushed in the same cycle. An entry popped in the flush cycle is discarded.
- **Reset:** count, pointers, lock, locked_src, resp_err and all tag entries clear to 0.
  - Outputs after reset: m_req=0 (requests are low), all addr_ok/data_ok = 0, busy=0, resp_err=0.
  - Reset mid-transaction abandons the FIFO. Downstream is reset together with the core.

## Timing
- Request path is combinational: req to m_req to m_addr_ok to addr_ok in the same cycle, with zero added latency.
- Response path is combinational: m_data_ok to port data_ok in the same cycle. rdata is passed straight through.
- Tag FIFO, count, lock and resp_err update on the clk edge after the event.
- Throughput: one accept and one response per cycle concurrently.
- busy reflects the registered count.

## Configuration
- **ARB_CANCEL_EN defined:** flush marks entries discard as described above.
- **ARB_CANCEL_EN undefined:**
  - The flush port is present but ignored.
  - The discard bit is not stored (tie to 0).
  - Every popped response raises data_ok on its src port.

## Test plan
- **Priority:** inst_req=1 and data_req=1 in the same cycle, m_addr_ok=1 → data_addr_ok=1, inst_addr_ok=0, m_addr=data_addr. Next cycle inst is accepted.
- **Lock:** inst_req alone, m_addr_ok=0 for 3 cycles, data_req rises in cycle 2 → m_addr stays inst_addr. inst_addr_ok pulses when m_addr_ok=1, then data is granted.
- **Ordering:** accept inst@0x100, data@0x200, inst@0x104, then three m_data_ok with rdata 0xA, 0xB, 0xC → inst_data_ok (0xA), data_data_ok (0xB), inst_data_ok (0xC).
- **Full:** 4 accepts without response → count=4 and m_req=0 despite inst_req=1. One m_data_ok → m_req=1 on the next cycle.
- **Flush (ARB_CANCEL_EN):** 2 outstanding, flush=1 in the same cycle as a third accept → the next 3 m_data_ok produce no port data_ok. A 4th request issued after the flush responds normally. busy=0 after the last response.
- **Error:** m_data_ok with count=0 → resp_err=1 next cycle, no data_ok on either port. resp_err stays 1 until reset.
